// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised RXD line, with the bytes
// queued in a small FIFO behind a valid/ready pop port and sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_rxd,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  input  logic                          i_clr_err
);

  localparam int BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta_reg, rx_s_reg, rx_prev_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             stop_sample;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [7:0]       head_reg, head_next;
  logic             frame_err_reg, overrun_reg;
  logic             pop, push, full, stop_good, frame_set, overrun_set;

  // rx_prev_reg trails rx_s_reg so a start needs a genuine high-to-low transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
    end else begin
      rx_meta_reg <= i_rxd;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    stop_sample = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          shift_next[bit_reg] = rx_s_reg;
          cnt_next = '0;
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          stop_sample = 1'b1;
          cnt_next    = '0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign full        = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop         = o_valid & i_ready;
  assign stop_good   = stop_sample & rx_s_reg;
  assign push        = stop_good & (!full | pop);
  assign overrun_set = stop_good & full & !pop;
  assign frame_set   = stop_sample & !rx_s_reg;

  // The head register holds whatever entry will sit at rd_ptr after this cycle's push/pop.
  always_comb begin
    head_next  = head_reg;
    level_next = level_reg + LVL_W'(push) - LVL_W'(pop);
    if (pop) begin
      if (level_reg != LVL_W'(1)) head_next = mem[rd_ptr_reg + PTR_W'(1)];
      else if (push)              head_next = shift_reg;
    end else if (push && level_reg == '0) begin
      head_next = shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      head_reg      <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg     <= level_next;
      head_reg      <= head_next;
      frame_err_reg <= frame_set   | (frame_err_reg & !i_clr_err);
      overrun_reg   <= overrun_set | (overrun_reg & !i_clr_err);
    end
  end

  assign o_data      = head_reg;
  assign o_valid     = (level_reg != '0);
  assign o_level     = level_reg;
  assign o_busy      = (state_reg != IDLE);
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised + directed bench for uart_rx_fifo: a queue-based reference FIFO, fed by
// the frame driver at the predicted stop-sample cycle, is compared with the DUT every cycle.
module tb_uart_rx_fifo;
  localparam int CLK_HZ   = 240000;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 4;
  localparam int BITC     = CLK_HZ / BAUD;
  localparam int HALF     = BITC / 2;
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  // 2 synchroniser flops + 1 edge-detect cycle, then half a bit plus 9 bit times.
  localparam int STOP_OFS = 3 + HALF + 9 * BITC;

  logic             clk, resetn, rxd, i_ready, i_clr_err;
  logic [7:0]       o_data;
  logic             o_valid, o_busy, o_frame_err, o_overrun;
  logic [LVL_W-1:0] o_level;

  uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .i_rxd(rxd), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_level(o_level), .o_busy(o_busy), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .i_clr_err(i_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        pend_q[$];
  logic [7:0] model_q[$];
  bit         m_fe, m_ov;
  bit         rand_mode = 1'b0;

  // Reference model: checks the DUT, then applies the pop/push/flag rules for the next edge.
  always @(negedge clk) begin
    bit   do_pop, have_ev, full;
    ev_t  ev;
    if (!resetn) begin
      model_q.delete();
      pend_q.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      check("level", 32'(o_level), 32'(model_q.size()));
      check("valid", 32'(o_valid), 32'(model_q.size() != 0));
      check("frame_err", 32'(o_frame_err), 32'(m_fe));
      check("overrun", 32'(o_overrun), 32'(m_ov));
      do_pop = i_ready && (model_q.size() > 0);
      if (do_pop) begin
        check("pop_data", 32'(o_data), 32'(model_q[0]));
        $display("pop  data=%02h level=%0d", o_data, o_level);
      end
      have_ev = (pend_q.size() > 0) && (pend_q[0].at == cyc + 1);
      if (have_ev) ev = pend_q.pop_front();
      full = (model_q.size() == DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (i_clr_err) begin
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      if (have_ev) begin
        if (!ev.ok)                 m_fe = 1'b1;
        else if (full && !do_pop)   m_ov = 1'b1;
        else                        model_q.push_back(ev.b);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      i_ready   = ($urandom_range(0, 3) == 0);
      i_clr_err = ($urandom_range(0, 63) == 0);
    end
  end

  // Called at posedge+1; drives the first nbits of the 10-bit frame and returns at posedge+1.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int nbits, input bit track);
    int   n;
    ev_t  ev;
    n = cyc;
    if (track && nbits == 10) begin
      ev.at = n + STOP_OFS;
      ev.b  = b;
      ev.ok = stop;
      pend_q.push_back(ev);
    end
    $display("send data=%02h stop=%0d bits=%0d", b, stop, nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (BITC) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int k);
    rxd = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    i_clr_err = 1'b1;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_level"}, 32'(o_level), 0);
    check({tag, "_data"},  32'(o_data), 0);
    check({tag, "_fe"},    32'(o_frame_err), 0);
    check({tag, "_ov"},    32'(o_overrun), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int         n0, busy_c, valid_c;
    logic [7:0] fill [4];
    logic [7:0] exp2 [4];
    logic [7:0] b;
    bit         ok;

    resetn = 1'b0; rxd = 1'b1; i_ready = 1'b0; i_clr_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("por");
    resetn = 1'b1;
    idle(5);

    // Exact latency of a single byte, then a single pop.
    n0 = cyc; busy_c = -1; valid_c = -1;
    fork
      send_frame(8'h55, 1'b1, 10, 1'b1);
      begin
        for (int k = 0; k < STOP_OFS + 20; k++) begin
          @(negedge clk);
          if (o_busy && busy_c < 0) busy_c = cyc;
          if (o_valid) begin
            valid_c = cyc;
            break;
          end
        end
      end
    join
    check("busy_rise", 32'(busy_c - n0), 3);
    check("valid_rise", 32'(valid_c - n0), 32'(STOP_OFS));
    @(negedge clk);
    check("t1_data", 32'(o_data), 32'h55);
    check("t1_level", 32'(o_level), 1);
    @(posedge clk); #1;
    pulse_ready();
    @(negedge clk);
    check("t1_empty", 32'(o_valid), 0);
    @(posedge clk); #1;

    // Five back-to-back bytes into a 4-deep FIFO: last one is lost.
    exp2[0] = 8'h01; exp2[1] = 8'hA5; exp2[2] = 8'hFF; exp2[3] = 8'h00;
    for (int k = 0; k < 4; k++) send_frame(exp2[k], 1'b1, 10, 1'b1);
    send_frame(8'h3C, 1'b1, 10, 1'b1);
    idle(BITC);
    @(negedge clk);
    check("t2_ov", 32'(o_overrun), 1);
    check("t2_level", 32'(o_level), 4);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_order", 32'(o_data), 32'(exp2[k]));
      @(posedge clk); #1;
      pulse_ready();
    end
    pulse_clr();
    @(negedge clk);
    check("t2_clr", 32'(o_overrun), 0);
    check("t2_empty", 32'(o_valid), 0);
    @(posedge clk); #1;

    // Short low glitch: START aborts at mid-bit.
    rxd = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    #1;
    rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy", 32'(o_busy), 1);
    repeat (HALF + 4) @(posedge clk);
    #1;
    @(negedge clk);
    check("glitch_idle", 32'(o_busy), 0);
    check("glitch_valid", 32'(o_valid), 0);
    @(posedge clk); #1;

    // Low stop bit, line held low: frame error, no retrigger; then a good byte.
    send_frame(8'hC3, 1'b0, 10, 1'b1);
    repeat (4 * BITC) @(posedge clk);
    #1;
    @(negedge clk);
    check("fe_set", 32'(o_frame_err), 1);
    check("fe_busy", 32'(o_busy), 0);
    check("fe_level", 32'(o_level), 0);
    @(posedge clk); #1;
    idle(5);
    send_frame(8'h7E, 1'b1, 10, 1'b1);
    idle(BITC);
    @(negedge clk);
    check("t4_data", 32'(o_data), 32'h7E);
    @(posedge clk); #1;
    pulse_clr();
    pulse_ready();

    // Full FIFO with a pop on exactly the stop-sample cycle.
    for (int k = 0; k < 4; k++) begin
      fill[k] = 8'($urandom_range(0, 255));
      send_frame(fill[k], 1'b1, 10, 1'b1);
    end
    n0 = cyc;
    fork
      send_frame(8'hB4, 1'b1, 10, 1'b1);
      begin
        while (cyc < n0 + STOP_OFS - 1) begin
          @(posedge clk); #1;
        end
        pulse_ready();
      end
    join
    @(negedge clk);
    check("t5_level", 32'(o_level), 4);
    check("t5_ov", 32'(o_overrun), 0);
    check("t5_head", 32'(o_data), 32'(fill[1]));
    @(posedge clk); #1;
    i_ready = 1'b1;
    idle(6);
    i_ready = 1'b0;

    // Reset in the middle of a frame, with data queued and a flag set.
    send_frame(8'h11, 1'b0, 10, 1'b1);
    idle(4);
    send_frame(8'h22, 1'b1, 10, 1'b1);
    send_frame(8'hE7, 1'b1, 5, 1'b0);
    @(negedge clk);
    check("mid_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    rxd = 1'b1;
    resetn = 1'b0;
    check_reset_vals("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(5);
    send_frame(8'h92, 1'b1, 10, 1'b1);
    idle(BITC);
    @(negedge clk);
    check("t6_data", 32'(o_data), 32'h92);
    check("t6_level", 32'(o_level), 1);
    @(posedge clk); #1;
    pulse_ready();

    // Randomised traffic with random pops and clears.
    rand_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, 10, 1'b1);
      idle(ok ? $urandom_range(0, 2 * BITC) : $urandom_range(4, 2 * BITC));
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
    i_ready = 1'b1;
    idle(2 * BITC);
    i_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(o_valid), 0);
    check("drain_pending", 32'(pend_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
